// File: rtl/hearts_display.sv
`default_nettype none
// ============================================================================
//  Module   : hearts_display
//  Purpose  : Player lives tracker with hit invulnerability/blink window and a
//             registered 16x16 heart-row renderer for the VGA object mux.
//  Revision : 1.0  initial release
// ============================================================================
module hearts_display #(
    parameter int         INIT_LIVES    = 3,
    parameter int         MAX_LIVES     = 5,
    parameter int         HEART_X0      = 16,
    parameter int         HEART_Y0      = 16,
    parameter int         HEART_GAP     = 4,
    parameter int         INVULN_FRAMES = 60,
    parameter int         BLINK_FRAMES  = 8,
    parameter logic [7:0] HEART_COLOR   = 8'hE0
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        hit,
    input  logic        addLife,
    input  logic        gameRestart,
    output logic        heartDrawingRequest,
    output logic [7:0]  heartRGB,
    output logic [3:0]  livesCount,
    output logic        gameOver
);

    localparam int PITCH = 16 + HEART_GAP;
    localparam int IW    = $clog2(INVULN_FRAMES + 1);
    localparam int BW    = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HURT      = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      lives_q, lives_d;
    logic [IW-1:0]   invuln_q, invuln_d;
    logic [BW-1:0]   blink_q, blink_d;
    logic            blink_on_q, blink_on_d;
    logic            draw_q, draw_d;
    logic [7:0]      rgb_q;
    logic            game_over_q;

    logic [3:0]      lives_inc;
    logic [10:0]     slot_x;
    logic [3:0]      row_idx;
    logic [3:0]      col_idx;
    logic [15:0]     row_bits;
    logic            y_in;

    // Row word: bit 15 is column 0 (leftmost pixel).
    function automatic logic [15:0] heart_row(input logic [3:0] r);
        case (r)
            4'd1:    heart_row = 16'h381C;
            4'd2:    heart_row = 16'h7C3E;
            4'd3:    heart_row = 16'hFE7F;
            4'd4:    heart_row = 16'hFFFF;
            4'd5:    heart_row = 16'hFFFF;
            4'd6:    heart_row = 16'hFFFF;
            4'd7:    heart_row = 16'h7FFE;
            4'd8:    heart_row = 16'h3FFC;
            4'd9:    heart_row = 16'h1FF8;
            4'd10:   heart_row = 16'h0FF0;
            4'd11:   heart_row = 16'h07E0;
            4'd12:   heart_row = 16'h03C0;
            4'd13:   heart_row = 16'h0180;
            default: heart_row = 16'h0000;
        endcase
    endfunction

    assign lives_inc = (lives_q < 4'(MAX_LIVES)) ? lives_q + 4'd1 : lives_q;

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        invuln_d   = invuln_q;
        blink_d    = blink_q;
        blink_on_d = blink_on_q;
        if (gameRestart) begin
            state_d    = ST_IDLE;
            lives_d    = 4'(INIT_LIVES);
            invuln_d   = '0;
            blink_d    = '0;
            blink_on_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        if (lives_q > 4'd1) begin
                            state_d    = ST_HURT;
                            lives_d    = lives_q - 4'd1;
                            invuln_d   = IW'(INVULN_FRAMES);
                            blink_d    = BW'(BLINK_FRAMES);
                            blink_on_d = 1'b1;
                        end else begin
                            state_d = ST_GAME_OVER;
                            lives_d = 4'd0;
                        end
                    end else if (addLife) begin
                        lives_d = lives_inc;
                    end
                end
                ST_HURT: begin
                    if (addLife) begin
                        lives_d = lives_inc;
                    end
                    if (startOfFrame) begin
                        invuln_d = invuln_q - IW'(1);
                        blink_d  = blink_q - BW'(1);
                        if (blink_q <= BW'(1)) begin
                            blink_on_d = ~blink_on_q;
                            blink_d    = BW'(BLINK_FRAMES);
                        end
                        if (invuln_q <= IW'(1)) begin
                            invuln_d = '0;
                            state_d  = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_GAME_OVER;
                end
            endcase
        end
    end

    assign y_in     = (pixelY >= 11'(HEART_Y0)) && (pixelY < 11'(HEART_Y0 + 16));
    assign row_idx  = 4'(pixelY - 11'(HEART_Y0));
    assign row_bits = heart_row(row_idx);

    // Slot under the pixel is found by comparing against each slot's span.
    always_comb begin
        draw_d  = 1'b0;
        slot_x  = '0;
        col_idx = '0;
        for (int i = 0; i < MAX_LIVES; i++) begin
            slot_x = 11'(HEART_X0 + i * PITCH);
            if (y_in && (pixelX >= slot_x) && (pixelX < slot_x + 11'd16)) begin
                col_idx = 4'(pixelX - slot_x);
                if (row_bits[~col_idx] &&
                    ((4'(i) < lives_q) ||
                     ((state_q == ST_HURT) && (4'(i) == lives_q) && blink_on_q))) begin
                    draw_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            lives_q     <= 4'(INIT_LIVES);
            invuln_q    <= '0;
            blink_q     <= '0;
            blink_on_q  <= 1'b0;
            draw_q      <= 1'b0;
            rgb_q       <= 8'h00;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            invuln_q    <= invuln_d;
            blink_q     <= blink_d;
            blink_on_q  <= blink_on_d;
            draw_q      <= draw_d;
            rgb_q       <= draw_d ? HEART_COLOR : 8'h00;
            game_over_q <= (lives_d == 4'd0);
        end
    end

    assign heartDrawingRequest = draw_q;
    assign heartRGB            = rgb_q;
    assign livesCount          = lives_q;
    assign gameOver            = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_hearts_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hearts_display
//  Purpose  : Directed self-checking bench for hearts_display.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hearts_display;

    logic        clk;
    logic        resetN;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        hit;
    logic        addLife;
    logic        gameRestart;
    logic        heartDrawingRequest;
    logic [7:0]  heartRGB;
    logic [3:0]  livesCount;
    logic        gameOver;

    int n_vec = 0;
    int n_err = 0;

    hearts_display u_dut (
        .clk                 (clk),
        .resetN              (resetN),
        .pixelX              (pixelX),
        .pixelY              (pixelY),
        .startOfFrame        (startOfFrame),
        .hit                 (hit),
        .addLife             (addLife),
        .gameRestart         (gameRestart),
        .heartDrawingRequest (heartDrawingRequest),
        .heartRGB            (heartRGB),
        .livesCount          (livesCount),
        .gameOver            (gameOver)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle event pulse; outputs are stable 1 ns after the consuming edge.
    task automatic ev(input bit h, input bit a, input bit r, input bit s);
        @(posedge clk); #1;
        hit = h; addLife = a; gameRestart = r; startOfFrame = s;
        @(posedge clk); #1;
        hit = 0; addLife = 0; gameRestart = 0; startOfFrame = 0;
    endtask

    task automatic frames(input int n);
        repeat (n) ev(0, 0, 0, 1);
    endtask

    task automatic pix(input int x, input int y);
        @(posedge clk); #1;
        pixelX = 11'(x); pixelY = 11'(y);
        @(posedge clk); #1;
    endtask

    // Pixel at row 5 (solid), column 4 of slot i.
    task automatic check_slot(input string tag, input int i, input bit exp);
        pix(16 + 20 * i + 4, 21);
        check(tag, heartDrawingRequest, exp);
    endtask

    initial begin
        resetN = 0; pixelX = 0; pixelY = 0;
        startOfFrame = 0; hit = 0; addLife = 0; gameRestart = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_lives", livesCount, 3);
        check("rst_req", heartDrawingRequest, 0);
        check("rst_rgb", heartRGB, 8'h00);
        check("rst_gover", gameOver, 0);
        @(negedge clk); resetN = 1;

        // Bitmap and slot geometry
        pix(16, 20);
        check("s0_r4c0_req", heartDrawingRequest, 1);
        check("s0_r4c0_rgb", heartRGB, 8'hE0);
        pix(16, 16);
        check("s0_r0_dark", heartDrawingRequest, 0);
        check("s0_r0_rgb", heartRGB, 8'h00);
        pix(16, 17);
        check("s0_r1c0_dark", heartDrawingRequest, 0);
        pix(18, 17);
        check("s0_r1c2_lit", heartDrawingRequest, 1);
        pix(33, 21);
        check("gap_dark", heartDrawingRequest, 0);
        pix(20, 32);
        check("below_dark", heartDrawingRequest, 0);
        check_slot("slot1_lit", 1, 1);
        check_slot("slot2_lit", 2, 1);
        check_slot("slot3_dark", 3, 0);

        // Hit -> HURT, blinking slot 2
        ev(1, 0, 0, 0);
        check("hit_lives", livesCount, 2);
        check_slot("blink_f0", 2, 1);
        frames(7);
        check_slot("blink_f7", 2, 1);
        frames(1);
        check_slot("blink_f8", 2, 0);
        frames(2);
        ev(1, 0, 0, 0);
        check("hit_ignored", livesCount, 2);
        frames(6);
        check_slot("blink_f16", 2, 1);
        frames(34);
        check_slot("blink_f50", 2, 1);
        frames(10);
        check_slot("idle_f60", 2, 0);
        ev(1, 0, 0, 0);
        check("idle_hit", livesCount, 1);

        // addLife saturation
        ev(0, 0, 1, 0);
        check("restart_lives", livesCount, 3);
        ev(0, 1, 0, 0); check("add_4", livesCount, 4);
        ev(0, 1, 0, 0); check("add_5", livesCount, 5);
        ev(0, 1, 0, 0); check("add_sat1", livesCount, 5);
        ev(0, 1, 0, 0); check("add_sat2", livesCount, 5);
        check_slot("slot4_lit", 4, 1);

        // Same-cycle hit+addLife
        ev(0, 0, 1, 0);
        ev(1, 1, 0, 0);
        check("hit_add_idle", livesCount, 2);
        ev(0, 1, 0, 0);
        check("add_in_hurt", livesCount, 3);
        check_slot("hurt_slot2_solid", 2, 1);
        ev(1, 1, 0, 0);
        check("hit_add_hurt", livesCount, 4);

        // Down to game over
        ev(0, 0, 1, 0);
        ev(1, 0, 0, 0);
        frames(60);
        ev(1, 0, 0, 0);
        check("go_lives1", livesCount, 1);
        check("go_not_yet", gameOver, 0);
        frames(60);
        ev(1, 0, 0, 0);
        check("go_lives0", livesCount, 0);
        check("go_flag", gameOver, 1);
        check_slot("go_slot0_dark", 0, 0);
        ev(0, 1, 0, 0);
        check("go_add_ignored", livesCount, 0);
        ev(0, 0, 1, 0);
        check("go_restart_lives", livesCount, 3);
        check("go_restart_flag", gameOver, 0);

        // Async reset in the middle of HURT
        ev(1, 0, 0, 0);
        pix(16, 20);
        check("pre_rst_req", heartDrawingRequest, 1);
        #2 resetN = 0;
        #1;
        check("arst_req", heartDrawingRequest, 0);
        check("arst_rgb", heartRGB, 8'h00);
        check("arst_lives", livesCount, 3);
        check("arst_gover", gameOver, 0);
        @(negedge clk); resetN = 1;
        check_slot("post_rst_slot3", 3, 0);
        ev(1, 0, 0, 0);
        check("post_rst_hit", livesCount, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
